// File: rtl/codec_ctrl_pkg.sv
// Shared types and constants for the codec control-port arbiter.
//   state_e        : frame-level states (IDLE/SETUP/SHIFT/HOLD/GAP)
//   WORD_W/ADDR_W/DATA_W : control word layout {addr[6:0], data[8:0]}
//   ADDR_*         : codec register addresses
//   make_word()    : packs an address/data pair into a control word
package codec_ctrl_pkg;

  localparam int unsigned WORD_W = 16;
  localparam int unsigned ADDR_W = 7;
  localparam int unsigned DATA_W = 9;

  typedef enum logic [2:0] {
    StIdle,
    StSetup,
    StShift,
    StHold,
    StGap
  } state_e;

  localparam logic [ADDR_W-1:0] ADDR_LINVOL = 7'h00;
  localparam logic [ADDR_W-1:0] ADDR_HPVOL  = 7'h02;
  localparam logic [ADDR_W-1:0] ADDR_APATH  = 7'h04;
  localparam logic [ADDR_W-1:0] ADDR_DPATH  = 7'h05;
  localparam logic [ADDR_W-1:0] ADDR_PWR    = 7'h06;
  localparam logic [ADDR_W-1:0] ADDR_IFACE  = 7'h07;
  localparam logic [ADDR_W-1:0] ADDR_SAMPLE = 7'h08;
  localparam logic [ADDR_W-1:0] ADDR_ACTIVE = 7'h09;
  localparam logic [ADDR_W-1:0] ADDR_RESET  = 7'h0F;

  function automatic logic [WORD_W-1:0] make_word(input logic [ADDR_W-1:0] addr,
                                                  input logic [DATA_W-1:0] data);
    return {addr, data};
  endfunction

endpackage

// File: rtl/codec_spi_shifter.sv
// Serialises one 16-bit control word: SETUP, 16 sck periods, HOLD.
//   clk, reset : clock, async active-high reset
//   start_i    : one-cycle pulse, loads word_i and begins the frame
//   word_i     : control word, sent MSB first
//   done_o     : high in the last HOLD cycle (combinational, for the arbiter)
//   spi_sck_o, spi_mosi_o, cs_n_o : registered codec pins
module codec_spi_shifter
  import codec_ctrl_pkg::*;
#(
  parameter int unsigned CLKDIV = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start_i,
  input  logic [WORD_W-1:0] word_i,
  output logic              done_o,
  output logic              spi_sck_o,
  output logic              spi_mosi_o,
  output logic              cs_n_o
);

  localparam int unsigned DivW = (CLKDIV > 1) ? $clog2(CLKDIV) : 1;

  state_e            phase_q, phase_d;
  logic [DivW-1:0]   div_q, div_d;
  // Half-period index: 0 = setup, 1..32 = shift halves (odd low, even high), 33 = hold.
  logic [5:0]        half_q, half_d;
  logic [WORD_W-1:0] sr_q, sr_d;
  logic              sck_q, sck_d, mosi_q, mosi_d, cs_n_q, cs_n_d;
  logic              div_last;

  assign div_last = (div_q == DivW'(CLKDIV - 1));

  always_comb begin
    phase_d = phase_q;
    div_d   = div_q;
    half_d  = half_q;
    sr_d    = sr_q;
    sck_d   = sck_q;
    mosi_d  = mosi_q;
    cs_n_d  = cs_n_q;
    done_o  = 1'b0;
    if (start_i) begin
      phase_d = StSetup;
      div_d   = '0;
      half_d  = '0;
      sr_d    = word_i;
      cs_n_d  = 1'b0;
      sck_d   = 1'b0;
      mosi_d  = word_i[WORD_W-1];
    end else if (phase_q != StIdle) begin
      if (!div_last) begin
        div_d = div_q + DivW'(1);
      end else begin
        div_d = '0;
        if (phase_q == StHold) begin
          done_o  = 1'b1;
          phase_d = StIdle;
          cs_n_d  = 1'b1;
          sck_d   = 1'b0;
          mosi_d  = 1'b0;
        end else begin
          half_d = half_q + 6'd1;
          if (half_q == 6'd32) begin
            phase_d = StHold;
            sck_d   = 1'b0;
          end else begin
            phase_d = StShift;
            if (half_q[0]) begin
              sck_d = 1'b1;
            end else begin
              sck_d = 1'b0;
              // Leaving setup, bit 15 is already on mosi; later low phases advance.
              if (half_q != 6'd0) begin
                sr_d   = sr_q << 1;
                mosi_d = sr_q[WORD_W-2];
              end
            end
          end
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      phase_q <= StIdle;
      div_q   <= '0;
      half_q  <= '0;
      sr_q    <= '0;
      sck_q   <= 1'b0;
      mosi_q  <= 1'b0;
      cs_n_q  <= 1'b1;
    end else begin
      phase_q <= phase_d;
      div_q   <= div_d;
      half_q  <= half_d;
      sr_q    <= sr_d;
      sck_q   <= sck_d;
      mosi_q  <= mosi_d;
      cs_n_q  <= cs_n_d;
    end
  end

  assign spi_sck_o  = sck_q;
  assign spi_mosi_o = mosi_q;
  assign cs_n_o     = cs_n_q;

endmodule

// File: rtl/codec_ctrl_arbiter.sv
// Round-robin arbiter sharing the codec 3-wire control port between NUM_REQ requesters.
//   clk, reset : clock, async active-high reset
//   req        : per-requester request level, held until ack
//   word       : requester i word at [16*i +: 16]
//   ack        : one-cycle pulse when cs rises after the requester's word
//   busy       : high whenever a frame or inter-frame gap is in progress
//   cs, spi_sck, spi_mosi : registered codec pins
module codec_ctrl_arbiter
  import codec_ctrl_pkg::*;
#(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned CLKDIV  = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [WORD_W*NUM_REQ-1:0] word,
  output logic [NUM_REQ-1:0]        ack,
  output logic                      busy,
  output logic                      cs,
  output logic                      spi_sck,
  output logic                      spi_mosi
);

  localparam int unsigned IdxW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned DivW = (CLKDIV > 1) ? $clog2(CLKDIV) : 1;

  // StShift covers the whole SETUP/SHIFT/HOLD span owned by the shifter.
  state_e            state_q, state_d;
  logic [IdxW-1:0]   rr_q, rr_d, grant_q, grant_d;
  logic [DivW-1:0]   gap_q, gap_d;
  logic [NUM_REQ-1:0] ack_q, ack_d;
  logic              busy_q, busy_d;

  logic              pick_valid;
  logic [IdxW-1:0]   pick_idx;
  int unsigned       scan_idx;
  logic [WORD_W-1:0] sel_word;
  logic              start, done;

  // First set request at or after rr_q, wrapping.
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = '0;
    scan_idx   = 0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      scan_idx = (32'(rr_q) + i) % NUM_REQ;
      if (!pick_valid && req[IdxW'(scan_idx)]) begin
        pick_valid = 1'b1;
        pick_idx   = IdxW'(scan_idx);
      end
    end
  end

  assign sel_word = word[pick_idx*WORD_W +: WORD_W];

  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    grant_d = grant_q;
    gap_d   = gap_q;
    ack_d   = '0;
    start   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (pick_valid) begin
          start   = 1'b1;
          grant_d = pick_idx;
          rr_d    = (pick_idx == IdxW'(NUM_REQ - 1)) ? '0 : pick_idx + IdxW'(1);
          state_d = StShift;
        end
      end
      StShift: begin
        if (done) begin
          state_d        = StGap;
          gap_d          = '0;
          ack_d[grant_q] = 1'b1;
        end
      end
      StGap: begin
        if (gap_q == DivW'(CLKDIV - 1)) begin
          state_d = StIdle;
        end else begin
          gap_d = gap_q + DivW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      rr_q    <= '0;
      grant_q <= '0;
      gap_q   <= '0;
      ack_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      grant_q <= grant_d;
      gap_q   <= gap_d;
      ack_q   <= ack_d;
      busy_q  <= busy_d;
    end
  end

  codec_spi_shifter #(
    .CLKDIV(CLKDIV)
  ) u_shifter (
    .clk       (clk),
    .reset     (reset),
    .start_i   (start),
    .word_i    (sel_word),
    .done_o    (done),
    .spi_sck_o (spi_sck),
    .spi_mosi_o(spi_mosi),
    .cs_n_o    (cs)
  );

  assign ack  = ack_q;
  assign busy = busy_q;

endmodule
